// File: rtl/wreg_pkg.sv
// -----------------------------------------------------------------------------
// wreg_pkg
// Shared definitions for the windowed register file: default geometry and the
// refill state encoding used by wreg_fill_ctrl.
// Optional feature macro used elsewhere in this slice: WREG_BOUNDS_FAULT_EN.
// -----------------------------------------------------------------------------
package wreg_pkg;

    localparam int WREG_DATA_W     = 16;
    localparam int WREG_PHYS_DEPTH = 16;
    localparam int WREG_WIN_SIZE   = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } wreg_state_e;

endpackage

// File: rtl/wreg_fill_ctrl.sv
// -----------------------------------------------------------------------------
// wreg_fill_ctrl
// IDLE/FILL sequencer for the window cache. Owns the per-entry valid bits, the
// fill index and Busy. The datapath in the top level uses fill_en_o/fill_idx_o
// to copy one physical register into the cache per FILL cycle.
//
// Ports
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   move_req_i  frame-move request from the host
//   move_ok_i   move passes the bounds check (tied high when unchecked)
//   wr_mask_i   one bit per window entry written this cycle
//   move_acc_o  move accepted this cycle (FP may update)
//   busy_o      refill in progress
//   fill_en_o   cache[fill_idx_o] must be loaded this cycle
//   fill_idx_o  current fill index
//   valid_o     per-entry valid bits
// -----------------------------------------------------------------------------
module wreg_fill_ctrl
    import wreg_pkg::*;
#(
    parameter int WIN_SIZE = WREG_WIN_SIZE,
    parameter int AW       = $clog2(WIN_SIZE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                move_req_i,
    input  logic                move_ok_i,
    input  logic [WIN_SIZE-1:0] wr_mask_i,
    output logic                move_acc_o,
    output logic                busy_o,
    output logic                fill_en_o,
    output logic [AW-1:0]       fill_idx_o,
    output logic [WIN_SIZE-1:0] valid_o
);

    wreg_state_e         state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [WIN_SIZE-1:0] valid_q, valid_d;

    assign busy_o     = (state_q == FILL);
    assign move_acc_o = move_req_i && move_ok_i && (state_q == IDLE);
    // An entry already written under the new frame must not be refilled.
    assign fill_en_o  = busy_o && !valid_q[idx_q];
    assign fill_idx_o = idx_q;
    assign valid_o    = valid_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q | wr_mask_i;
        case (state_q)
            IDLE: begin
                if (move_acc_o) begin
                    // Writes in the move cycle target the old frame, so they
                    // must not mark entries of the new frame valid.
                    state_d = FILL;
                    idx_d   = '0;
                    valid_d = '0;
                end
            end
            FILL: begin
                if (fill_en_o) valid_d[idx_q] = 1'b1;
                if (idx_q == AW'(WIN_SIZE - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/windowed_regfile.sv
// -----------------------------------------------------------------------------
// windowed_regfile
// Register file of PHYS_DEPTH physical registers seen through a WIN_SIZE-entry
// window at frame pointer FP. Reads come from a window cache with zero latency;
// moving the frame refills the cache over WIN_SIZE cycles (Busy high).
//
// Ports
//   Clock, Reset                sole clock, synchronous active-high reset
//   Rd_Addr, Rs_Addr, Rm_Addr   window-relative addresses (AW bits)
//   Rd_Wen/Rd_Data, Rs_Wen/Rs_Data   write ports (Rd wins on same address)
//   Win_Move, Win_Up, Win_Step  frame-move request, direction, distance
//   Rd_Out, Rs_Out, Rm_Out      cache read data
//   FP_Out                      current frame pointer
//   Busy                        refill in progress
//   Fault                       sticky bounds violation (WREG_BOUNDS_FAULT_EN)
//
// Macro WREG_BOUNDS_FAULT_EN: when defined, moves leaving FP outside
// [0, PHYS_DEPTH-WIN_SIZE] are rejected and raise Fault; otherwise FP wraps.
// -----------------------------------------------------------------------------
module windowed_regfile
    import wreg_pkg::*;
#(
    parameter  int DATA_W     = WREG_DATA_W,
    parameter  int PHYS_DEPTH = WREG_PHYS_DEPTH,
    parameter  int WIN_SIZE   = WREG_WIN_SIZE,
    localparam int AW         = $clog2(WIN_SIZE),
    localparam int PW         = $clog2(PHYS_DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [AW-1:0]     Rd_Addr,
    input  logic [AW-1:0]     Rs_Addr,
    input  logic [AW-1:0]     Rm_Addr,
    input  logic              Rd_Wen,
    input  logic              Rs_Wen,
    input  logic [DATA_W-1:0] Rd_Data,
    input  logic [DATA_W-1:0] Rs_Data,
    input  logic              Win_Move,
    input  logic              Win_Up,
    input  logic [PW-1:0]     Win_Step,
    output logic [DATA_W-1:0] Rd_Out,
    output logic [DATA_W-1:0] Rs_Out,
    output logic [DATA_W-1:0] Rm_Out,
    output logic [PW-1:0]     FP_Out,
`ifdef WREG_BOUNDS_FAULT_EN
    output logic              Fault,
`endif
    output logic              Busy
);

    logic [DATA_W-1:0]   phys_q  [PHYS_DEPTH];
    logic [DATA_W-1:0]   cache_q [WIN_SIZE];
    logic [PW-1:0]       fp_q, fp_d;
    logic [PW-1:0]       rd_pa, rs_pa, fill_pa;
    logic [WIN_SIZE-1:0] wr_mask;
    logic [WIN_SIZE-1:0] valid;
    logic [AW-1:0]       fill_idx;
    logic                move_ok, move_acc, fill_en;

    // Physical addressing wraps naturally at PW bits.
    assign rd_pa   = fp_q + PW'(Rd_Addr);
    assign rs_pa   = fp_q + PW'(Rs_Addr);
    assign fill_pa = fp_q + PW'(fill_idx);
    assign fp_d    = Win_Up ? (fp_q + Win_Step) : (fp_q - Win_Step);

    always_comb begin
        wr_mask = '0;
        if (Rs_Wen) wr_mask[Rs_Addr] = 1'b1;
        if (Rd_Wen) wr_mask[Rd_Addr] = 1'b1;
    end

`ifdef WREG_BOUNDS_FAULT_EN
    logic          fault_q;
    logic [PW:0]   fp_up_wide;

    // One extra bit so an upward move past PHYS_DEPTH is not hidden by wrap.
    assign fp_up_wide = {1'b0, fp_q} + {1'b0, Win_Step};
    assign move_ok    = Win_Up ? (fp_up_wide <= (PW+1)'(PHYS_DEPTH - WIN_SIZE))
                               : (Win_Step <= fp_q);
    assign Fault      = fault_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fault_q <= 1'b0;
        end else if (Win_Move && !Busy && !move_ok) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign move_ok = 1'b1;
`endif

    wreg_fill_ctrl #(
        .WIN_SIZE (WIN_SIZE),
        .AW       (AW)
    ) u_fill_ctrl (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .move_req_i (Win_Move),
        .move_ok_i  (move_ok),
        .wr_mask_i  (wr_mask),
        .move_acc_o (move_acc),
        .busy_o     (Busy),
        .fill_en_o  (fill_en),
        .fill_idx_o (fill_idx),
        .valid_o    (valid)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < PHYS_DEPTH; i++) phys_q[i] <= '0;
            for (int i = 0; i < WIN_SIZE; i++)   cache_q[i] <= '0;
            fp_q <= '0;
        end else begin
            if (move_acc) fp_q <= fp_d;
            // Fill first so a same-cycle write to the same entry overrides it.
            if (fill_en) cache_q[fill_idx] <= phys_q[fill_pa];
            // Rs before Rd: Rd wins on an address collision.
            if (Rs_Wen) begin
                phys_q[rs_pa] <= Rs_Data;
                if (!move_acc) cache_q[Rs_Addr] <= Rs_Data;
            end
            if (Rd_Wen) begin
                phys_q[rd_pa] <= Rd_Data;
                if (!move_acc) cache_q[Rd_Addr] <= Rd_Data;
            end
        end
    end

    assign Rd_Out = cache_q[Rd_Addr];
    assign Rs_Out = cache_q[Rs_Addr];
    assign Rm_Out = cache_q[Rm_Addr];
    assign FP_Out = fp_q;

endmodule

// File: doc/windowed_regfile.md
WINDOWED_REGFILE -- requirements
Module: windowed_regfile

Interface
REQ-001 Parameter DATA_W, default 16, register data width in bits.
REQ-002 Parameter PHYS_DEPTH, default 16, number of physical registers; power of two, at least 2*WIN_SIZE.
REQ-003 Parameter WIN_SIZE, default 8, number of architecturally visible registers; power of two.
REQ-004 Derived widths: AW = log2(WIN_SIZE) for window addresses; PW = log2(PHYS_DEPTH) for the frame pointer and physical addresses.
REQ-005 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Rd_Addr, Rs_Addr, Rm_Addr  input  AW  window-relative register addresses.
REQ-008 Rd_Wen, Rs_Wen  input  1  write enables for the Rd and Rs ports.
REQ-009 Rd_Data, Rs_Data  input  DATA_W  write data.
REQ-010 Win_Move  input  1  frame-move request; accepted only when Busy=0.
REQ-011 Win_Up  input  1  move direction: 1 = FP+Win_Step, 0 = FP-Win_Step.
REQ-012 Win_Step  input  PW  frame-move distance.
REQ-013 Rd_Out, Rs_Out, Rm_Out  output  DATA_W  combinational reads of window-cache entries [Rd_Addr], [Rs_Addr], [Rm_Addr].
REQ-014 FP_Out  output  PW  current frame pointer.
REQ-015 Busy  output  1  high while a window refill is in progress.
REQ-016 Fault  output  1  sticky bounds-violation flag (present only per REQ-034).

Function
REQ-017 Physical address = (FP + window address) mod PHYS_DEPTH, computed at PW bits.
REQ-018 The window cache holds WIN_SIZE entries, each with a valid bit; reads return cache contents with zero latency.
REQ-019 In IDLE with no move: each enabled write updates physical[phys(addr)] and cache[addr] at the clock edge, and sets that entry's valid bit.
REQ-020 If both ports write the same address in one cycle, Rd wins in both the physical array and the cache.
REQ-021 Move acceptance: Win_Move=1 with Busy=0 in IDLE.
REQ-022 Accepted move: FP updates to FP +/- Win_Step mod PHYS_DEPTH; all valid bits clear; the state goes to FILL with fill index 0.
REQ-023 Writes in the move cycle use the old FP for physical addressing and do not set valid bits.
REQ-024 FILL state: each cycle, cache[idx] loads physical[phys(idx)] under the new FP unless the entry is already valid.
REQ-025 FILL state: idx increments each cycle; after idx = WIN_SIZE-1 the state returns to IDLE.
REQ-026 A refill takes exactly WIN_SIZE cycles; Busy is 1 for exactly those cycles.
REQ-027 Writes during FILL target the new FP, update the physical array and cache, and set the valid bit; a write beats a fill to the same index in the same cycle.
REQ-028 Win_Move while Busy=1 is ignored: no FP change and no restart.
REQ-029 During FILL, outputs for not-yet-valid entries show stale cache data; the host stalls reads until Busy=0.
REQ-030 States are exactly IDLE and FILL; there are no other transitions.

Reset
REQ-031 Reset clears the physical array, the cache, FP_Out, Busy, Fault and the fill index to 0, sets all valid bits, and sets the state to IDLE.
REQ-032 Reset overrides all writes and moves in the same cycle.
REQ-033 Reset during FILL aborts the refill; the next cycle is IDLE with Busy=0.

Configuration
REQ-034 Macro WREG_BOUNDS_FAULT_EN defined: a move is rejected if it would give FP > PHYS_DEPTH-WIN_SIZE or FP < 0 (unsigned underflow).
REQ-035 A rejected move leaves FP, the cache and the state unchanged, and sets Fault=1 until Reset.
REQ-036 Macro WREG_BOUNDS_FAULT_EN undefined: FP and physical addresses wrap modulo PHYS_DEPTH, the Fault port is absent, and no moves are rejected.

Structure
REQ-037 Package wreg_pkg holds the state enum {IDLE, FILL} and default values for DATA_W, PHYS_DEPTH and WIN_SIZE.
REQ-038 Sub-module wreg_fill_ctrl contains the IDLE/FILL FSM, the fill index, the valid-bit vector and the Busy output; the top level holds the arrays and datapath.

Verification
REQ-039 After Reset: write Rd_Addr=3, data 0xA5A5 -> next cycle Rd_Addr=3 reads 0xA5A5; physical[3]=0xA5A5.
REQ-040 FP=0, Win_Move, Win_Up=1, Win_Step=4 -> FP_Out=4; Busy high for 8 cycles; afterwards window address 0 reads the earlier physical[4] value.
REQ-041 During FILL cycle 2, write Rs_Addr=6 with 0x1234 -> after Busy falls, address 6 reads 0x1234 (not overwritten by fill); physical[10]=0x1234.
REQ-042 Rd and Rs both write address 2 with 0x1111 and 0x2222 -> address 2 reads 0x1111; Win_Move while Busy -> FP unchanged and Busy length unchanged.
REQ-043 With WREG_BOUNDS_FAULT_EN defined: FP=8, Win_Up=1, Win_Step=4 -> FP stays 8 and Fault=1. Without the macro: FP=12, Win_Step=8 up -> FP_Out=4, and window address 5 maps to physical 9.
REQ-044 Assert Reset in FILL cycle 3 -> next cycle Busy=0, FP_Out=0, and all outputs read 0.
